// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-way round-robin mux arbiter.
// The burst-lock build is selected with the MUX_ARB_LOCK_EN macro.
package mux_arb_pkg;

   localparam int NUM_REQ    = 4;
   localparam int DEF_DATA_W = 64;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
      logic [1:0] idx;
      idx = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (oh[i]) idx = 2'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/mux_arb_4_if.sv
// Requester/downstream bundle for mux_arb_4; slave = arbiter side, master = environment side.
interface mux_arb_4_if
   import mux_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
);

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        last;
   logic [NUM_REQ*DATA_W-1:0] in_data;
   logic [NUM_REQ-1:0]        in_ready;
   logic                      out_valid;
   logic                      out_ready;
   logic [DATA_W-1:0]         out_data;
   logic [1:0]                out_src;
   logic                      out_last;

   modport slave (
      input  req, last, in_data, out_ready,
      output in_ready, out_valid, out_data, out_src, out_last
   );

   modport master (
      output req, last, in_data, out_ready,
      input  in_ready, out_valid, out_data, out_src, out_last
   );

endinterface

// File: rtl/rr_pick4.sv
// Rotated-priority picker: first set req bit scanning ptr, ptr+1, ... mod 4.
module rr_pick4
   import mux_arb_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] grant
);

   logic [1:0] w_idx;
   logic       w_found;

   // NOTE: every variable written here gets a default first so no latch is inferred.
   always_comb begin
      grant   = '0;
      w_found = 1'b0;
      w_idx   = ptr;
      for (int k = 0; k < NUM_REQ; k++) begin
         w_idx = ptr + 2'(k);
         if (!w_found && req[w_idx]) begin
            grant[w_idx] = 1'b1;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_arb_4.sv
// 4-way round-robin arbiter feeding a single registered output slot.
// Define MUX_ARB_LOCK_EN to hold the grant on one requester until its last beat.
module mux_arb_4
   import mux_arb_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic       clk,
   input  logic       rst_n,
   mux_arb_4_if.slave bus
);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [1:0]          r_ptr;
   logic [1:0]          r_owner;
   logic                r_out_valid;
   logic [DATA_W-1:0]   r_out_data;
   logic [1:0]          r_out_src;
   logic                r_out_last;

   logic [NUM_REQ-1:0]  w_rr_grant;
   logic [NUM_REQ-1:0]  w_grant;
   logic [NUM_REQ-1:0]  w_in_ready;
   logic                w_slot_free;
   logic                w_accept;
   logic                w_end_arb;
   logic [1:0]          w_win;

   rr_pick4 u_rr_pick4 (
      .req   (bus.req),
      .ptr   (r_ptr),
      .grant (w_rr_grant)
   );

   // NOTE: state lives in always_ff with non-blocking assignments only.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
`ifdef MUX_ARB_LOCK_EN
      unique case (r_state)
         IDLE: if (w_accept && !bus.last[w_win]) w_state_nxt = BUSY;
         BUSY: if (w_accept &&  bus.last[w_win]) w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
`else
      w_state_nxt = IDLE;
`endif
   end

   // in_ready is gated by rst_n because req reaches the grant combinationally.
   always_comb begin
      w_grant     = (r_state == BUSY) ? (bus.req & (4'b0001 << r_owner)) : w_rr_grant;
      w_slot_free = !r_out_valid || bus.out_ready;
      w_in_ready  = rst_n ? (w_grant & {NUM_REQ{w_slot_free}}) : '0;
      w_accept    = |w_in_ready;
      w_win       = onehot_to_idx(w_grant);
`ifdef MUX_ARB_LOCK_EN
      w_end_arb   = w_accept && bus.last[w_win];
`else
      w_end_arb   = w_accept;
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr   <= 2'd0;
         r_owner <= 2'd0;
      end else if (w_accept) begin
         if (w_end_arb)         r_ptr   <= w_win + 2'd1;
         if (r_state == IDLE)   r_owner <= w_win;
      end
   end

   // NOTE: the output register is a handful of flops, so data is reset along with valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_src   <= 2'd0;
         r_out_last  <= 1'b0;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_out_data  <= bus.in_data[w_win*DATA_W +: DATA_W];
         r_out_src   <= w_win;
         r_out_last  <= bus.last[w_win];
      end else if (bus.out_ready) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_src   = r_out_src;
   assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_mux_arb_4.sv
// Scoreboard bench for mux_arb_4; lock scenarios run only when MUX_ARB_LOCK_EN is defined.
module tb_mux_arb_4;
   import mux_arb_pkg::*;

   localparam int DW = 64;

   typedef struct packed {
      logic [DW-1:0] data;
      logic [1:0]    src;
      logic          last;
   } beat_t;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   mux_arb_4_if #(.DATA_W(DW)) bif ();

   mux_arb_4 #(.DATA_W(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bif)
   );

   int    n_vec = 0;
   int    n_err = 0;
   beat_t sb_q[$];
   logic  m_valid;
   logic  m_busy;
   int    m_ptr;
   int    m_owner;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, act, exp);
      end
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_busy  = 1'b0;
      m_ptr   = 0;
      m_owner = 0;
      sb_q.delete();
   endtask

   function automatic logic [3:0] model_grant();
      logic [3:0] g;
      g = 4'b0000;
      if (m_busy) begin
         g[m_owner] = bif.req[m_owner];
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (g == 4'b0000 && bif.req[(m_ptr + k) % 4]) g[(m_ptr + k) % 4] = 1'b1;
         end
      end
      return g;
   endfunction

   task automatic set_data(input logic [63:0] base);
      for (int i = 0; i < 4; i++) bif.in_data[i*DW +: DW] = base + 64'(i);
   endtask

   // One clock: check outputs at the negedge against the model/scoreboard, then advance.
   task automatic step(input string tag);
      logic [3:0] rdy;
      int         w;
      beat_t      b;
      @(negedge clk);
      rdy = (!m_valid || bif.out_ready) ? model_grant() : 4'b0000;
      check({tag, ":in_ready"},  64'(bif.in_ready),  64'(rdy));
      check({tag, ":out_valid"}, 64'(bif.out_valid), 64'(m_valid));
      if (m_valid) begin
         check({tag, ":sb_depth"}, 64'(sb_q.size()), 64'd1);
         if (sb_q.size() > 0) begin
            b = sb_q[0];
            check({tag, ":out_data"}, bif.out_data,        b.data);
            check({tag, ":out_src"},  64'(bif.out_src),    64'(b.src));
            check({tag, ":out_last"}, 64'(bif.out_last),   64'(b.last));
            if (bif.out_ready) void'(sb_q.pop_front());
         end
      end
      if (rdy != 4'b0000) begin
         w = 0;
         for (int i = 0; i < 4; i++) if (rdy[i]) w = i;
         b.data = bif.in_data[w*DW +: DW];
         b.src  = 2'(w);
         b.last = bif.last[w];
         sb_q.push_back(b);
`ifdef MUX_ARB_LOCK_EN
         if (!m_busy && !b.last) begin
            m_busy  = 1'b1;
            m_owner = w;
         end else if (b.last) begin
            m_busy = 1'b0;
            m_ptr  = (w + 1) % 4;
         end
`else
         m_ptr = (w + 1) % 4;
`endif
         m_valid = 1'b1;
      end else if (bif.out_ready) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n         = 1'b1;
      bif.req       = '0;
      bif.last      = '0;
      bif.out_ready = 1'b0;
      bif.in_data   = '0;
      model_reset();
      #1 rst_n = 1'b0;
      bif.req = 4'hF;
      #2;
      check("rst:in_ready",  64'(bif.in_ready),  64'd0);
      check("rst:out_valid", 64'(bif.out_valid), 64'd0);
      check("rst:out_data",  bif.out_data,       64'd0);
      check("rst:out_src",   64'(bif.out_src),   64'd0);
      check("rst:out_last",  64'(bif.out_last),  64'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // All requesters active, single-beat bursts: pure rotation 0,1,2,3,0.
      bif.req       = 4'hF;
      bif.last      = 4'hF;
      bif.out_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         set_data(64'h100 * 64'(k + 1));
         step("rr");
         check("rr:src_seq", 64'(bif.out_src), 64'(k % 4));
      end

      // Idle drain: valid falls after one cycle, pointer must not move.
      bif.req = 4'h0;
      step("idle1");
      check("idle1:valid_low", 64'(bif.out_valid), 64'd0);
      step("idle2");
      bif.req = 4'hF;
      step("ptr_hold");
      check("ptr_hold:src", 64'(bif.out_src), 64'd1);

      // Backpressure: held beat stays stable, next beat loads on release.
      bif.req  = 4'b0001;
      set_data(64'h0);
      bif.in_data[0 +: DW] = 64'hA5A5;
      step("stall_load");
      check("stall_load:data", bif.out_data, 64'hA5A5);
      bif.out_ready = 1'b0;
      bif.in_data[0 +: DW] = 64'h1234;
      for (int k = 0; k < 3; k++) begin
         step("stall");
         check("stall:data_hold", bif.out_data, 64'hA5A5);
      end
      bif.out_ready = 1'b1;
      step("stall_release");
      check("stall_release:data", bif.out_data, 64'h1234);
      bif.req = 4'h0;
      step("drain");

`ifdef MUX_ARB_LOCK_EN
      // Three-beat burst from 0 with requester 1 waiting; 1's last bit is ignored.
      set_data(64'h300);
      bif.req  = 4'b0001;
      bif.last = 4'b0010;
      step("burst_b0");
      check("burst_b0:src", 64'(bif.out_src), 64'd0);
      bif.req = 4'b0011;
      step("burst_b1");
      check("burst_b1:src", 64'(bif.out_src), 64'd0);
      bif.last = 4'b0011;
      step("burst_b2");
      check("burst_b2:src", 64'(bif.out_src), 64'd0);
      step("burst_next");
      check("burst_next:src", 64'(bif.out_src), 64'd1);

      // Owner drops req mid-burst; requester 2 must not get through.
      set_data(64'h400);
      bif.req  = 4'b0001;
      bif.last = 4'b0000;
      step("own_b0");
      check("own_b0:src", 64'(bif.out_src), 64'd0);
      bif.req = 4'b0100;
      for (int k = 0; k < 2; k++) begin
         step("own_drop");
         check("own_drop:valid_low", 64'(bif.out_valid), 64'd0);
      end
      bif.req  = 4'b0101;
      bif.last = 4'b0001;
      step("own_last");
      check("own_last:src", 64'(bif.out_src), 64'd0);
      bif.req  = 4'b0100;
      bif.last = 4'b0000;
      step("own_after");
      check("own_after:src", 64'(bif.out_src), 64'd2);
`endif

      // Reset in the middle of a held beat / open burst.
      set_data(64'h500);
      bif.req  = 4'b0001;
      bif.last = 4'b0000;
      step("pre_rst");
      bif.out_ready = 1'b0;
      step("pre_rst_hold");
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst:in_ready",  64'(bif.in_ready),  64'd0);
      check("mid_rst:out_valid", 64'(bif.out_valid), 64'd0);
      check("mid_rst:out_data",  bif.out_data,       64'd0);
      check("mid_rst:out_src",   64'(bif.out_src),   64'd0);
      check("mid_rst:out_last",  64'(bif.out_last),  64'd0);
      model_reset();
      @(posedge clk);
      #1;
      bif.req       = 4'b0110;
      bif.last      = 4'b0110;
      bif.out_ready = 1'b1;
      rst_n         = 1'b1;
      step("post_rst");
      check("post_rst:src", 64'(bif.out_src), 64'd1);

      bif.req = 4'h0;
      step("end1");
      step("end2");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
